// File: rtl/exchange_judge_pkg.sv
// exchange_judge_pkg: shared widths, types and saturation helper for the Metropolis exchange judge.
package exchange_judge_pkg;
    localparam int EXP_Y_W    = 24;
    localparam int EXP_Y_FRAC = 17;
    localparam int EXP_X_W    = 22;
    localparam int EXP_X_FRAC = 16;
    localparam int RECIP_FRAC = 15;
    typedef logic signed [EXP_Y_W-1:0] exp_y_t;
    typedef logic signed [EXP_X_W-1:0] exp_x_t;
    localparam exp_y_t Y_ONE = exp_y_t'(1 << EXP_Y_FRAC);
    localparam logic signed [63:0] Y_MAX = (64'sd1 <<< (EXP_Y_W-1)) - 64'sd1;
    localparam logic signed [63:0] Y_MIN = -(64'sd1 <<< (EXP_Y_W-1));
    function automatic exp_y_t sat_y(input logic signed [63:0] v);
        return v > Y_MAX ? exp_y_t'(Y_MAX) : v < Y_MIN ? exp_y_t'(Y_MIN) : exp_y_t'(v);
    endfunction
endpackage

// File: rtl/exp_horner_step.sv
// exp_horner_step: one Horner step y' = 1 + (x*y)*recip, full precision, floor shifts, saturated.
module exp_horner_step
    import exchange_judge_pkg::*;
(
    input  exp_x_t      x,
    input  exp_y_t      y,
    input  logic [16:0] recip,
    output exp_y_t      y_next
);
    logic signed [63:0] xy;
    logic signed [63:0] term;
    always_comb begin
        xy     = (64'(x) * 64'(y)) >>> EXP_X_FRAC;
        term   = (xy * $signed(64'(recip))) >>> RECIP_FRAC;
        y_next = sat_y(term + 64'(Y_ONE));
    end
endmodule

// File: rtl/exchange_judge.sv
// exchange_judge: evaluates exp(-beta*delta) by Horner series and makes a registered
// Metropolis accept/reject decision one cycle after exp_fin.
module exchange_judge
    import exchange_judge_pkg::*;
#(
    parameter int X_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               exp_init,
    input  logic               exp_run,
    input  logic               exp_fin,
    input  logic [16:0]        exp_recip,
    input  logic signed [23:0] delta,
    input  logic [15:0]        beta,
    input  logic [15:0]        rnd,
    output logic               accept,
    output logic               accept_valid,
    output logic [17:0]        exp_value
);
    localparam logic signed [47:0] XP_LIMIT = 48'(X_LIMIT) <<< EXP_X_FRAC;
    localparam exp_x_t X_SAT_MAX = {1'b0, {(EXP_X_W-1){1'b1}}};
    localparam exp_x_t X_SAT_MIN = {1'b1, {(EXP_X_W-1){1'b0}}};
    logic signed [47:0] xp;
    logic signed [47:0] nx;
    exp_x_t             x;
    exp_y_t             y;
    exp_y_t             y_next;
    logic               armed;
    logic               force_acc;
    logic               force_rej;
    logic [17:0]        y_clamp;
    logic               decide;
    logic               verdict;
    exp_horner_step u_step (
        .x      (x),
        .y      (y),
        .recip  (exp_recip),
        .y_next (y_next)
    );
    always_comb begin
        xp      = 48'(delta) * $signed(48'(beta));
        nx      = -xp;
        y_clamp = y < 0 ? 18'd0 : y > Y_ONE ? 18'(Y_ONE) : y[17:0];
        decide  = exp_fin && armed;
        verdict = force_acc ? 1'b1 : (force_rej || y < 0) ? 1'b0 : ({1'b0, rnd} < y_clamp[17:1]);
    end
    // decision reads the pre-edge state, so a coincident exp_init only affects the next evaluation
    always_ff @(posedge clk) begin
        if (reset) begin
            accept       <= 1'b0;
            accept_valid <= 1'b0;
            exp_value    <= '0;
            armed        <= 1'b0;
            y            <= '0;
            x            <= '0;
            force_acc    <= 1'b0;
            force_rej    <= 1'b0;
        end else begin
            accept_valid <= decide;
            if (decide) begin
                accept    <= verdict;
                exp_value <= y_clamp;
            end
            if (exp_init) begin
                armed     <= 1'b1;
                y         <= Y_ONE;
                x         <= nx > 48'(X_SAT_MAX) ? X_SAT_MAX : nx < 48'(X_SAT_MIN) ? X_SAT_MIN : nx[EXP_X_W-1:0];
                force_acc <= delta <= 0;
                force_rej <= xp > XP_LIMIT;
            end else begin
                if (exp_fin) armed <= 1'b0;
                if (exp_run) y <= y_next;
            end
        end
    end
endmodule

// File: tb/tb_exchange_judge.sv
// tb_exchange_judge: directed 20-cycle frames with a scoreboard of expected decisions.
module tb_exchange_judge;
    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               exp_init = 1'b0;
    logic               exp_run = 1'b0;
    logic               exp_fin = 1'b0;
    logic [16:0]        exp_recip = '0;
    logic signed [23:0] delta = '0;
    logic [15:0]        beta = '0;
    logic [15:0]        rnd = '0;
    logic               accept;
    logic               accept_valid;
    logic [17:0]        exp_value;
    typedef struct {
        logic acc;
        int   val;
        int   tol;
    } exp_t;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    exchange_judge #(.X_LIMIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .exp_init     (exp_init),
        .exp_run      (exp_run),
        .exp_fin      (exp_fin),
        .exp_recip    (exp_recip),
        .delta        (delta),
        .beta         (beta),
        .rnd          (rnd),
        .accept       (accept),
        .accept_valid (accept_valid),
        .exp_value    (exp_value)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask
    task automatic chk_tol(input string tag, input int obs, input int expv, input int tol);
        vectors++;
        assert (obs >= expv - tol && obs <= expv + tol) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, expv, tol);
        end
    endtask
    function automatic int recip_of(input int k);
        return (32768 + k / 2) / k;
    endfunction
    always @(negedge clk) begin
        if (accept_valid === 1'b1) begin
            vectors++;
            assert (sb.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_valid: observed pulse expected none");
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_accept", {31'd0, accept}, {31'd0, e.acc});
                if (e.tol >= 0) chk_tol("sb_exp_value", int'(exp_value), e.val, e.tol);
            end
        end
    end
    // one controller frame; rst_at >= 0 pulses reset in that cycle and cancels the decision
    task automatic frame(input logic signed [23:0] d, input logic [15:0] b, input logic [15:0] r,
                         input logic acc, input int val, input int tol, input int rst_at);
        exp_t e;
        for (int c = 0; c < 20; c++) begin
            exp_init  = (c == 0);
            exp_run   = (c >= 1 && c <= 15);
            exp_recip = exp_run ? 17'(recip_of(16 - c)) : 17'd0;
            exp_fin   = (c == 18);
            reset     = (c == rst_at);
            if (c == 0) begin
                delta = d;
                beta  = b;
            end
            rnd = (c == 18) ? r : 16'h1234;
            if (c == 18 && rst_at < 0) begin
                e.acc = acc;
                e.val = val;
                e.tol = tol;
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            if (c == 17) chk("no_early_valid", {31'd0, accept_valid}, 32'd0);
            if (c == 18) chk("valid_cycle19", {31'd0, accept_valid}, {31'd0, rst_at < 0});
            if (c == rst_at) begin
                chk("rst_accept", {31'd0, accept}, 32'd0);
                chk("rst_exp_value", {14'd0, exp_value}, 32'd0);
                chk("rst_valid", {31'd0, accept_valid}, 32'd0);
            end
        end
        exp_init = 1'b0;
        exp_run  = 1'b0;
        exp_fin  = 1'b0;
        reset    = 1'b0;
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_accept", {31'd0, accept}, 32'd0);
        chk("reset_valid", {31'd0, accept_valid}, 32'd0);
        chk("reset_exp_value", {14'd0, exp_value}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        frame(24'sd0, 16'h8000, 16'hFFFF, 1'b1, 131072, 0, -1);
        frame(24'sd1, 16'hFFFF, 16'h5E00, 1'b1, 48218, 4, -1);
        exp_fin = 1'b1;
        @(posedge clk);
        #1;
        exp_fin = 1'b0;
        chk("orphan_fin_valid", {31'd0, accept_valid}, 32'd0);
        chk("orphan_fin_accept", {31'd0, accept}, 32'd1);
        chk_tol("orphan_fin_exp_value", int'(exp_value), 48218, 4);
        @(posedge clk);
        #1;
        frame(24'sd0, 16'h8000, 16'hFFFF, 1'b1, 0, -1, 8);
        chk("post_rst_accept", {31'd0, accept}, 32'd0);
        chk("post_rst_exp_value", {14'd0, exp_value}, 32'd0);
        frame(24'sd1, 16'hFFFF, 16'h5F00, 1'b0, 48218, 4, -1);
        frame(24'sd5, 16'hFFFF, 16'h0000, 1'b0, 0, -1, -1);
        frame(-24'sd3, 16'h8000, 16'hFFFF, 1'b1, 131072, 0, -1);
        frame(24'sd1, 16'h8000, 16'hFFFF, 1'b0, 79500, 4, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
